// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU result path: default datapath width,
//   bit positions inside the 4-bit flag vector, the flag vector type and a
//   helper that derives a flag vector from one ALU result.
//
//   Flag vector layout (MSB..LSB): {carry, ovf, neg, zero}
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default width of results, accumulator and FIFO data entries.
  localparam int ALU_WIDTH = 16;

  // Bit positions inside the flag vector.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;

  // Number of flag bits stored alongside every FIFO entry.
  localparam int FLAG_BITS = 4;

  typedef logic [FLAG_BITS-1:0] flags_t;

  // Builds the flag vector for a result. The sign bit is passed in
  // separately so the function stays independent of the datapath width.
  function automatic flags_t make_flags(input logic is_zero,
                                        input logic sign_bit,
                                        input logic carry,
                                        input logic ovf);
    flags_t f;
    f             = '0;
    f[FLAG_ZERO]  = is_zero;
    f[FLAG_NEG]   = sign_bit;
    f[FLAG_OVF]   = ovf;
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
//   Small synchronous FIFO holding ALU results together with their flags.
//   The head entry is always presented on pop_data straight from storage
//   at the read pointer, so a pushed entry is visible one edge after the push
//   when the FIFO was empty.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (clears pointers and count)
//     push       write push_data at the write pointer (ignored when full)
//     push_data  entry to write
//     pop        advance the read pointer (ignored when empty)
//     pop_data   entry at the read pointer
//     full       count == DEPTH
//     empty      count == 0
//     count      number of occupied entries
// ---------------------------------------------------------------------------
module result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic do_push;
  logic do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is written only on an accepted push and is deliberately left
  // out of reset; stale contents are unreachable once the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and a
  // pop on the same edge advance both pointers and leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_unit.sv
// ---------------------------------------------------------------------------
// alu_result_unit
//   Collects ALU results: derives flags, maintains an accumulator with a
//   sticky overflow bit and a running result count, and queues every
//   accepted result (with its flags) in an output FIFO.
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     res_valid   ALU result offered this cycle
//     res_data    ALU result value
//     res_carry   adder carry-out
//     res_ovf     adder signed overflow
//     res_ready   unit can accept a result (FIFO not full)
//     acc_we      load the accepted result into the accumulator
//     acc_clr     clear accumulator and sticky overflow (wins over acc_we)
//     acc_val     accumulator value
//     flags       {carry, ovf, neg, zero} of the last accepted result
//     ovf_sticky  set by any accepted result with overflow
//     out_valid   FIFO head valid
//     out_data    FIFO head result
//     out_flags   flags stored with the FIFO head
//     out_ready   consumer takes the head
//     fifo_count  occupied FIFO entries
//     res_cnt     number of accepted results, wraps at 16 bits
// ---------------------------------------------------------------------------
module alu_result_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_valid,
  input  logic [WIDTH-1:0]       res_data,
  input  logic                   res_carry,
  input  logic                   res_ovf,
  output logic                   res_ready,
  input  logic                   acc_we,
  input  logic                   acc_clr,
  output logic [WIDTH-1:0]       acc_val,
  output logic [3:0]             flags,
  output logic                   ovf_sticky,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [3:0]             out_flags,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            res_cnt
);

  localparam int EW = WIDTH + FLAG_BITS;

  logic           accept;
  flags_t         new_flags;
  logic           fifo_full;
  logic           fifo_empty;
  logic [EW-1:0]  fifo_head;
  logic           pop;

  // res_ready depends only on occupancy, never on out_ready, so a full FIFO
  // refuses a new result even if the head is being drained on the same edge.
  assign res_ready = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = res_valid && res_ready;
  assign pop       = out_valid && out_ready;

  assign new_flags = make_flags((res_data == '0), res_data[WIDTH-1],
                                res_carry, res_ovf);

  assign out_flags = fifo_head[EW-1 -: FLAG_BITS];
  assign out_data  = fifo_head[WIDTH-1:0];

  result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({new_flags, res_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Accumulator: a clear takes priority over a load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_val <= '0;
    end else if (acc_clr) begin
      acc_val <= '0;
    end else if (accept && acc_we) begin
      acc_val <= res_data;
    end
  end

  // Sticky overflow: an overflowing result accepted on the same edge as a
  // clear must still be remembered, so the set beats the clear here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (accept && res_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (acc_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  // Flags of the last accepted result; held while nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (accept) begin
      flags <= new_flags;
    end
  end

  // Accepted-result counter, wraps modulo 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (accept) begin
      res_cnt <= res_cnt + 16'd1;
    end
  end

endmodule
